// File: rtl/tick_generator.sv
// Programmable one-cycle enable source for the display counter:
// four tick rates, run/pause and single-step from a pushbutton.
module tick_generator #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 28
) (
  input  logic       CLOCK_50,
  input  logic       clear_n,
  input  logic [1:0] rate_sel,
  input  logic       run,
  input  logic       step_n,
  output logic       enable,
  output logic       running
);

  typedef enum logic {
    PAUSED,
    RUNNING
  } state_t;

  localparam logic [CNT_W-1:0] LD_1 = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] LD_2 = CNT_W'(2 * CLK_HZ - 1);
  localparam logic [CNT_W-1:0] LD_4 = CNT_W'(4 * CLK_HZ - 1);

  function automatic logic [CNT_W-1:0] load_of(
    input logic [1:0] r
  );
    case (r)
      2'b01:   load_of = LD_1;
      2'b10:   load_of = LD_2;
      2'b11:   load_of = LD_4;
      default: load_of = '0;
    endcase
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       rate_q, rate_n;
  logic             en_n;

  logic run_m, run_s;
  logic step_m, step_s, step_h;
  logic step_fall;

  always_ff @(posedge CLOCK_50 or negedge clear_n) begin
    if (!clear_n) begin
      run_m  <= 1'b0;
      run_s  <= 1'b0;
      step_m <= 1'b1;
      step_s <= 1'b1;
      step_h <= 1'b1;
    end else begin
      run_m  <= run;
      run_s  <= run_m;
      step_m <= step_n;
      step_s <= step_m;
      step_h <= step_s;
    end
  end

  // A falling edge of the synced button, seen once per press.
  assign step_fall = step_h & ~step_s;

  always_ff @(posedge CLOCK_50 or negedge clear_n) begin
    if (!clear_n) begin
      state   <= PAUSED;
      cnt     <= '0;
      rate_q  <= 2'b00;
      enable  <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rate_q  <= rate_n;
      enable  <= en_n;
      running <= (state_n == RUNNING);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rate_n  = rate_q;
    en_n    = 1'b0;
    case (state)
      PAUSED: begin
        rate_n = rate_sel;
        if (run_s) begin
          state_n = RUNNING;
          cnt_n   = load_of(rate_sel);
        end else if (step_fall) begin
          en_n = 1'b1;
        end
      end
      RUNNING: begin
        if (!run_s) begin
          state_n = PAUSED;
        end else if (rate_sel != rate_q) begin
          rate_n = rate_sel;
          cnt_n  = load_of(rate_sel);
        end else if (cnt == '0) begin
          en_n  = 1'b1;
          cnt_n = load_of(rate_q);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = PAUSED;
    endcase
  end

endmodule

// File: doc/tick_generator.md
# tick_generator

Programmable one-cycle enable-pulse source that drives the 8-bit display counter's count enable. Selects one of four tick rates from switches, and supports a run/pause mode plus single-step from a pushbutton. Sits directly upstream of the counter: its `enable` output feeds the counter's increment qualifier on the same `CLOCK_50` domain.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: clock frequency. Defines 1 s = `CLK_HZ` cycles.
- `CNT_W`, default 28: down-counter width. Must hold 4*`CLK_HZ`-1.

Ports:
- `CLOCK_50`  input  1  system clock; all state on its rising edge.
- `clear_n`  input  1  one clock; reset is asynchronous and active-low.
- `rate_sel`  input  2  tick-rate select from switches; quasi-static, registered once into `rate_q`.
- `run`  input  1  level from a switch, asynchronous; 1 = free-run, 0 = pause.
- `step_n`  input  1  pushbutton, active-low, asynchronous; one press in pause produces one tick.
- `enable`  output  1  registered one-cycle tick pulse.
- `running`  output  1  registered; 1 while FSM is in RUNNING.

## Operation
- Period P from `rate_q`:
  - 00: P = 1 (every cycle).
  - 01: P = `CLK_HZ` (1 Hz).
  - 10: P = 2*`CLK_HZ`.
  - 11: P = 4*`CLK_HZ`.
- Loads are P-1, computed at width `CNT_W`.
- Synchronisers: `run` passes through 2 flops to give `run_s`. `step_n` passes through 2 flops, then a third history flop. `step_fall` = history high AND synced low.
- FSM states: PAUSED, RUNNING.
- PAUSED:
  - If `run_s`=1: go to RUNNING and set `cnt` <= P-1.
  - Else if `step_fall`: `enable` <= 1 for one cycle. `cnt` is held.
- RUNNING:
  - If `run_s`=0: go to PAUSED. `cnt` is held and no pulse is produced.
  - Else if `rate_sel` != `rate_q`: `rate_q` <= `rate_sel`, `cnt` <= new P-1, no pulse.
  - Else if `cnt`=0: `enable` <= 1 and `cnt` <= P-1.
  - Else: `cnt` <= `cnt`-1.
- In PAUSED, `rate_q` still tracks `rate_sel` each cycle. The new period takes effect at the RUNNING entry load.
- `enable` is 0 on every edge not listed above. It is never high for two consecutive cycles, except when P=1 in RUNNING.
- `step_fall` is ignored in RUNNING and on the edge that leaves PAUSED.
- A held button yields exactly one pulse. Release produces nothing.
- Counter never underflows: 0 always reloads to P-1.

## Timing
- Reset (`clear_n`=0, immediate, asynchronous) sets:
  - `enable`=0, `running`=0, state=PAUSED.
  - `cnt`=0, `rate_q`=00.
  - `run` syncs = 0; `step_n` syncs and history = 1.
- Release from reset: all behaviour is synchronous from the next edge.
- `run` rises before edge a:
  - `run_s`=1 after edge a+1.
  - RUNNING entered, and `running`=1, after edge a+2.
- First tick after entry at edge e0:
  - `enable` is high during the cycle following edge e0+P.
  - Subsequent ticks arrive every P cycles.
  - P=1: `enable` is high every cycle from e0+1 on.
- Step: `step_n` first sampled low at edge a; `enable` is high for the cycle after edge a+2 (3-edge latency).
- Simultaneous events:
  - `run_s` falling with `cnt`=0: no pulse, PAUSED.
  - Rate change with `cnt`=0: reload, no pulse.
- Reset mid-period: the pending tick is discarded and the FSM restarts from the reset state.

## Test plan
Simulate with `CLK_HZ`=4, so P = 1 / 4 / 8 / 16.
- Reset, then hold: `run`=0, `rate_sel`=01, idle 20 cycles -> `enable`=0 and `running`=0 throughout.
- Free run: `run`=1, `rate_sel`=01 -> `running`=1 after 2 edges, first `enable` 4 edges after entry, then exactly one pulse every 4 cycles over 40 cycles (10 pulses).
- Full speed and rate switch: `rate_sel`=00 in RUNNING -> `enable` high every cycle. Then switch to 11 -> one dead cycle with reload, then a pulse every 16 cycles.
- Single step: `run`=0, press `step_n` low for 10 cycles, release, press again -> exactly 2 one-cycle pulses, each 3 edges after the press is sampled. A press while `run`=1 adds no extra pulse.
- Pause and resume: in RUNNING with `rate_sel`=10, drop `run` on the edge where `cnt`=0 -> no pulse, PAUSED. Raise `run` -> next pulse 8 edges after re-entry.
- Async reset mid-period: assert `clear_n`=0 between clock edges while `cnt`=5 -> `enable`/`running` go to 0 immediately. After release, no pulse until `run` is re-synchronised and a full period elapses.
